mac_sequencer: RTL and testbench
================================

// Module: mac_sequencer
// PURPOSE
//  Sequences the 16x16+36 multiply-accumulate unit through an N-term dot product.
//  Fetches X (coefficient) and Y (sample) operands from two synchronous RAM ports
//  and issues one product per cycle. Feeds the registered MAC sum back as the
//  addend (R) and captures the 37-bit result. Sits between the DSP host/register
//  interface and the MAC in the Slipstream DSP datapath.
// PARAMETERS
//  ADDR_W   8   operand RAM address width; max run length 2**ADDR_W terms
// PORTS
//  clk        in   1         system clock
//  reset_n    in   1         synchronous active-low reset
//  start      in   1         begin run (sampled in IDLE only)
//  abort      in   1         cancel run in progress
//  x_base     in   ADDR_W    first X address
//  y_base     in   ADDR_W    first Y address
//  len        in   ADDR_W+1  term count, 0..2**ADDR_W
//  clear_acc  in   1         1: start from 0; 0: start from current result[35:0]
//  sign_x     in   1         X operands two's complement
//  sign_y     in   1         Y operands two's complement
//  x_rd       out  1         X RAM read strobe
//  x_addr     out  ADDR_W    X RAM address
//  x_data     in   16        X RAM data, valid the cycle after x_rd
//  y_rd       out  1         Y RAM read strobe
//  y_addr     out  ADDR_W    Y RAM address
//  y_data     in   16        Y RAM data, valid the cycle after y_rd
//  mac_x      out  16        MAC X operand
//  mac_y      out  16        MAC Y operand
//  mac_r      out  36        MAC addend
//  mac_tcx    out  1         MAC X signed (= sign_x latched)
//  mac_tcyl   out  1         MAC Y unsigned (= ~sign_y latched)
//  mac_z      in   37        MAC registered sum (1-cycle latency)
//  busy       out  1         run in progress
//  done       out  1         1-cycle pulse, result valid
//  result     out  37        last completed sum
//  overflow   out  1         sticky: bit 36 set on any step of last run
// BEHAVIOUR
//  - Reset: state IDLE; busy=done=overflow=0; result=0; x_rd=y_rd=0;
//    addresses=0; mac_x=mac_y=0; mac_r=0; mac_tcx=0; mac_tcyl=1.
//  - States: IDLE -> ISSUE -> RUN -> DRAIN -> DONE -> IDLE.
//  - IDLE: on start (len>0), latch base, len, sign, and clear_acc; clear overflow;
//    go to ISSUE. start is ignored when the block is not in IDLE.
//  - len=0: go directly to DONE. result is 0 (clear_acc=1) or unchanged.
//    overflow=0.
//  - Cycle 0 (ISSUE): x_rd=y_rd=1 at base addresses.
//  - Cycles 1..len-1 (RUN): reads continue at base+k.
//  - Addresses increment mod 2**ADDR_W (wrap 255->0 at ADDR_W=8).
//  - Cycle k+1 (k=0..len-1): mac_x=x_data, mac_y=y_data, combinational from
//    the RAM ports.
//  - Cycle k+1 addend: mac_r = init for k=0; mac_r = mac_z[35:0] for k>0.
//    init is 0 or result[35:0].
//  - Outside the issue window: mac_x=mac_y=0, mac_r=0.
//  - DRAIN (cycle len+1): mac_z holds the final sum; latch it into result.
//  - Overflow: set whenever mac_z[36]=1 during cycles 2..len+1. Bit 36 is not
//    fed back; the accumulator wraps at 36 bits.
//  - DONE (cycle len+2): done=1 for one cycle, busy=0; return to IDLE.
//    start is accepted again in the following cycle.
//  - busy=1 from the cycle after start through DRAIN.
//  - abort (any non-IDLE state): go to IDLE next cycle with no done pulse.
//    result and overflow are unchanged; reads stop immediately.
//  - abort has priority over all other transitions, including the DONE pulse.
//  - reset_n low mid-run: same as the reset values above; no done pulse.
//  - mac_tcx/mac_tcyl stay constant from ISSUE through DRAIN, then hold until
//    the next start.
// TESTING
//  - Unsigned run: x={1,2,3}, y={4,5,6}, len=3, clear_acc=1 -> done at cycle 5,
//    result=32, overflow=0.
//  - Signed run: sign_x=sign_y=1, x=16'hFFFF, y=16'h0002, len=1 -> mac_tcyl=0,
//    result=37'h1F_FFFF_FFFE (-2 in 37 bits).
//  - Accumulate: previous result=32, clear_acc=0, x={1}, y={10} -> result=42.
//    Then len=0, clear_acc=1 -> done next cycle, result=0.
//  - Wrap and overflow: x_base=y_base=8'hFE, len=4 -> addresses FE,FF,00,01.
//    All 16'hFFFF unsigned with clear_acc=0 and result=36'hF_FFFF_FFFF ->
//    overflow=1.
//  - Abort: len=10, abort at cycle 4 -> busy=0 next cycle, no done, result
//    unchanged. A start during the run is ignored.
//  - Reset mid-run at cycle 3 -> all outputs at reset values next cycle; a new
//    start runs cleanly.

Source files
------------

// File: rtl/mac_sequencer.sv
// mac_sequencer: runs an N-term dot product through the external 16x16+36 MAC.
// Each cycle it reads one X/Y operand pair from the two RAM ports and feeds the
// registered MAC sum back as the addend. At the end it captures the 37-bit
// total in result and flags overflow when bit 36 of any partial sum was set.
module mac_sequencer #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] x_base,
    input  logic [ADDR_W-1:0] y_base,
    input  logic [ADDR_W:0]   len,
    input  logic              clear_acc,
    input  logic              sign_x,
    input  logic              sign_y,
    output logic              x_rd,
    output logic [ADDR_W-1:0] x_addr,
    input  logic [15:0]       x_data,
    output logic              y_rd,
    output logic [ADDR_W-1:0] y_addr,
    input  logic [15:0]       y_data,
    output logic [15:0]       mac_x,
    output logic [15:0]       mac_y,
    output logic [35:0]       mac_r,
    output logic              mac_tcx,
    output logic              mac_tcyl,
    input  logic [36:0]       mac_z,
    output logic              busy,
    output logic              done,
    output logic [36:0]       result,
    output logic              overflow
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LEN_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_r;
    logic [ADDR_W:0]   rd_left_r;     // reads still to issue after the current one
    logic              x_rd_r;
    logic              y_rd_r;
    logic [ADDR_W-1:0] x_addr_r;
    logic [ADDR_W-1:0] y_addr_r;
    logic              valid_r;       // RAM data on x_data/y_data belongs to this run
    logic              first_r;       // first product of the run: addend is the init value
    logic              ovf_win_r;     // mac_z holds a partial sum of this run
    logic              clear_acc_r;
    logic              tcx_r;
    logic              tcyl_r;
    logic              busy_r;
    logic              done_r;
    logic [36:0]       result_r;
    logic              overflow_r;

    logic [15:0]       mac_x_s;
    logic [15:0]       mac_y_s;
    logic [35:0]       mac_r_s;

    // Route RAM data and the accumulator feedback onto the MAC inputs only while a product is due.
    always_comb begin
        mac_x_s = 16'h0000;
        mac_y_s = 16'h0000;
        mac_r_s = 36'h0_0000_0000;
        if (valid_r) begin
            mac_x_s = x_data;
            mac_y_s = y_data;
            if (first_r) begin
                if (clear_acc_r) begin
                    mac_r_s = 36'h0_0000_0000;
                end else begin
                    mac_r_s = result_r[35:0];
                end
            end else begin
                // Bit 36 is dropped: the accumulator wraps at 36 bits.
                mac_r_s = mac_z[35:0];
            end
        end else begin
            mac_x_s = 16'h0000;
            mac_y_s = 16'h0000;
            mac_r_s = 36'h0_0000_0000;
        end
    end

    // Sequencer FSM: read issue, pipeline tracking, result capture and status flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            rd_left_r   <= LEN_ZERO;
            x_rd_r      <= 1'b0;
            y_rd_r      <= 1'b0;
            x_addr_r    <= ADDR_ZERO;
            y_addr_r    <= ADDR_ZERO;
            valid_r     <= 1'b0;
            first_r     <= 1'b0;
            ovf_win_r   <= 1'b0;
            clear_acc_r <= 1'b0;
            tcx_r       <= 1'b0;
            tcyl_r      <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            result_r    <= 37'h00_0000_0000;
            overflow_r  <= 1'b0;
        end else if (abort && (state_r != ST_IDLE)) begin
            // Cancel: stop reading, discard the pipeline, keep result and overflow.
            state_r   <= ST_IDLE;
            x_rd_r    <= 1'b0;
            y_rd_r    <= 1'b0;
            valid_r   <= 1'b0;
            first_r   <= 1'b0;
            ovf_win_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            // Data returns one cycle after the read; the sum returns one cycle after that.
            valid_r   <= x_rd_r;
            first_r   <= (state_r == ST_ISSUE);
            ovf_win_r <= valid_r;
            done_r    <= 1'b0;
            if (ovf_win_r && mac_z[36]) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        tcx_r       <= sign_x;
                        tcyl_r      <= ~sign_y;
                        clear_acc_r <= clear_acc;
                        overflow_r  <= 1'b0;
                        if (len == LEN_ZERO) begin
                            // Empty run: finish at once, optionally clearing the result.
                            if (clear_acc) begin
                                result_r <= 37'h00_0000_0000;
                            end else begin
                                result_r <= result_r;
                            end
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            x_addr_r  <= x_base;
                            y_addr_r  <= y_base;
                            x_rd_r    <= 1'b1;
                            y_rd_r    <= 1'b1;
                            rd_left_r <= len - LEN_ONE;
                            busy_r    <= 1'b1;
                            state_r   <= ST_ISSUE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE, ST_RUN: begin
                    if (x_rd_r && (rd_left_r != LEN_ZERO)) begin
                        x_addr_r  <= x_addr_r + ADDR_ONE;
                        y_addr_r  <= y_addr_r + ADDR_ONE;
                        rd_left_r <= rd_left_r - LEN_ONE;
                    end else begin
                        x_rd_r <= 1'b0;
                        y_rd_r <= 1'b0;
                    end
                    // Reads have ended and the last operands are on the MAC this cycle.
                    if ((state_r == ST_RUN) && !x_rd_r) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    result_r <= mac_z;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b1;
                    state_r  <= ST_DONE;
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign x_rd     = x_rd_r;
    assign y_rd     = y_rd_r;
    assign x_addr   = x_addr_r;
    assign y_addr   = y_addr_r;
    assign mac_x    = mac_x_s;
    assign mac_y    = mac_y_s;
    assign mac_r    = mac_r_s;
    assign mac_tcx  = tcx_r;
    assign mac_tcyl = tcyl_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign result   = result_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: models the operand RAMs and the registered
// MAC around the sequencer and checks hand-computed results and timing.
module tb_mac_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [7:0]  x_base;
    logic [7:0]  y_base;
    logic [8:0]  len;
    logic        clear_acc;
    logic        sign_x;
    logic        sign_y;
    logic        x_rd;
    logic [7:0]  x_addr;
    logic [15:0] x_data = 16'h0000;
    logic        y_rd;
    logic [7:0]  y_addr;
    logic [15:0] y_data = 16'h0000;
    logic [15:0] mac_x;
    logic [15:0] mac_y;
    logic [35:0] mac_r;
    logic        mac_tcx;
    logic        mac_tcyl;
    logic [36:0] mac_z = 37'h0;
    logic        busy;
    logic        done;
    logic [36:0] result;
    logic        overflow;

    logic [15:0] mem_x [256];
    logic [15:0] mem_y [256];

    int total = 0;
    int bad   = 0;

    // run log filled by do_run
    int          cyc;
    int          nrd;
    logic [7:0]  xa_log [16];
    logic [7:0]  ya_log [16];
    logic        b0;
    logic [35:0] mr1;
    logic [15:0] mx1;
    logic [15:0] my1;

    mac_sequencer #(.ADDR_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .x_base(x_base), .y_base(y_base), .len(len), .clear_acc(clear_acc),
        .sign_x(sign_x), .sign_y(sign_y),
        .x_rd(x_rd), .x_addr(x_addr), .x_data(x_data),
        .y_rd(y_rd), .y_addr(y_addr), .y_data(y_data),
        .mac_x(mac_x), .mac_y(mac_y), .mac_r(mac_r),
        .mac_tcx(mac_tcx), .mac_tcyl(mac_tcyl), .mac_z(mac_z),
        .busy(busy), .done(done), .result(result), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // synchronous operand RAMs, one cycle read latency
    always @(posedge clk) begin
        if (x_rd) x_data <= mem_x[x_addr];
        if (y_rd) y_data <= mem_y[y_addr];
    end

    // registered MAC: z = x*y + r, signedness chosen by tcx/tcyl
    function automatic logic [36:0] mac_f(input logic [15:0] x, input logic [15:0] y,
                                          input logic [35:0] r, input logic tcx, input logic tcyl);
        logic signed [16:0] xs;
        logic signed [16:0] ys;
        logic signed [33:0] p;
        xs = tcx  ? {x[15], x} : {1'b0, x};
        ys = tcyl ? {1'b0, y}  : {y[15], y};
        p  = xs * ys;
        return {{3{p[33]}}, p} + {1'b0, r};
    endfunction

    always @(posedge clk) mac_z <= mac_f(mac_x, mac_y, mac_r, mac_tcx, mac_tcyl);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string pfx);
        chk({pfx, "_busy"},     {63'd0, busy},     64'd0);
        chk({pfx, "_done"},     {63'd0, done},     64'd0);
        chk({pfx, "_ovf"},      {63'd0, overflow}, 64'd0);
        chk({pfx, "_result"},   {27'd0, result},   64'd0);
        chk({pfx, "_rd"},       {62'd0, x_rd, y_rd}, 64'd0);
        chk({pfx, "_addr"},     {48'd0, x_addr, y_addr}, 64'd0);
        chk({pfx, "_macxy"},    {32'd0, mac_x, mac_y}, 64'd0);
        chk({pfx, "_macr"},     {28'd0, mac_r},    64'd0);
        chk({pfx, "_tc"},       {62'd0, mac_tcx, mac_tcyl}, 64'd1);
    endtask

    // start a run, then log reads and first-product operands until done
    task automatic do_run(input logic [7:0] xb, input logic [7:0] yb, input logic [8:0] ln,
                          input logic clr, input logic sx, input logic sy);
        x_base = xb; y_base = yb; len = ln; clear_acc = clr; sign_x = sx; sign_y = sy;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0; nrd = 0; b0 = busy; mr1 = '1; mx1 = '1; my1 = '1;
        while (!done && cyc < 200) begin
            if (x_rd && nrd < 16) begin
                xa_log[nrd] = x_addr;
                ya_log[nrd] = y_addr;
                nrd++;
            end
            if (cyc == 1) begin
                mr1 = mac_r; mx1 = mac_x; my1 = mac_y;
            end
            tick();
            cyc++;
        end
        if (!done) chk("done_timeout", 64'd0, 64'd1);
        tick();   // DONE -> IDLE before the next start
    endtask

    initial begin
        int done_cnt;
        for (int i = 0; i < 256; i++) begin
            mem_x[i] = 16'h0000;
            mem_y[i] = 16'h0000;
        end
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; x_base = 8'h00; y_base = 8'h00;
        len = 9'd0; clear_acc = 1'b0; sign_x = 1'b0; sign_y = 1'b0;
        tick();
        tick();
        check_reset_state("rst");
        reset_n = 1'b1;
        tick();

        // unsigned dot product 1*4+2*5+3*6
        mem_x[8'h10] = 16'd1; mem_x[8'h11] = 16'd2; mem_x[8'h12] = 16'd3;
        mem_y[8'h20] = 16'd4; mem_y[8'h21] = 16'd5; mem_y[8'h22] = 16'd6;
        do_run(8'h10, 8'h20, 9'd3, 1'b1, 1'b0, 1'b0);
        chk("u_cycles", 64'(cyc), 64'd5);
        chk("u_busy0",  {63'd0, b0}, 64'd1);
        chk("u_nreads", 64'(nrd), 64'd3);
        chk("u_xaddr2", {56'd0, xa_log[2]}, 64'h12);
        chk("u_yaddr0", {56'd0, ya_log[0]}, 64'h20);
        chk("u_macr1",  {28'd0, mr1}, 64'd0);
        chk("u_result", {27'd0, result}, 64'd32);
        chk("u_ovf",    {63'd0, overflow}, 64'd0);

        // accumulate onto previous 32
        mem_x[8'h40] = 16'd1; mem_y[8'h41] = 16'd10;
        do_run(8'h40, 8'h41, 9'd1, 1'b0, 1'b0, 1'b0);
        chk("acc_macr1",  {28'd0, mr1}, 64'd32);
        chk("acc_macxy1", {32'd0, mx1, my1}, {32'd0, 16'd1, 16'd10});
        chk("acc_cycles", 64'(cyc), 64'd3);
        chk("acc_result", {27'd0, result}, 64'd42);

        // empty run with clear
        do_run(8'h00, 8'h00, 9'd0, 1'b1, 1'b0, 1'b0);
        chk("z_cycles", 64'(cyc), 64'd0);
        chk("z_result", {27'd0, result}, 64'd0);

        // signed -1 * 2
        mem_x[8'h50] = 16'hFFFF; mem_y[8'h50] = 16'h0002;
        do_run(8'h50, 8'h50, 9'd1, 1'b1, 1'b1, 1'b1);
        chk("s_tc",     {62'd0, mac_tcx, mac_tcyl}, 64'd2);
        chk("s_result", {27'd0, result}, 64'h1F_FFFF_FFFE);
        chk("s_ovf",    {63'd0, overflow}, 64'd1);

        // signed -1 * 1 leaves result[35:0] all ones
        mem_y[8'h51] = 16'h0001;
        do_run(8'h50, 8'h51, 9'd1, 1'b1, 1'b1, 1'b1);
        chk("s2_result", {27'd0, result}, 64'h1F_FFFF_FFFF);

        // address wrap FE,FF,00,01, unsigned FFFF*FFFF accumulating onto F_FFFF_FFFF
        mem_x[8'hFE] = 16'hFFFF; mem_x[8'hFF] = 16'hFFFF; mem_x[8'h00] = 16'hFFFF; mem_x[8'h01] = 16'hFFFF;
        mem_y[8'hFE] = 16'hFFFF; mem_y[8'hFF] = 16'hFFFF; mem_y[8'h00] = 16'hFFFF; mem_y[8'h01] = 16'hFFFF;
        do_run(8'hFE, 8'hFE, 9'd4, 1'b0, 1'b0, 1'b0);
        chk("w_xaddr1", {56'd0, xa_log[1]}, 64'hFF);
        chk("w_xaddr2", {56'd0, xa_log[2]}, 64'h00);
        chk("w_yaddr3", {56'd0, ya_log[3]}, 64'h01);
        chk("w_tcyl",   {63'd0, mac_tcyl}, 64'd1);
        chk("w_result", {27'd0, result}, 64'h3_FFF8_0003);
        chk("w_ovf",    {63'd0, overflow}, 64'd1);

        // empty run without clear keeps result, clears overflow
        do_run(8'h00, 8'h00, 9'd0, 1'b0, 1'b0, 1'b0);
        chk("z2_result", {27'd0, result}, 64'h3_FFF8_0003);
        chk("z2_ovf",    {63'd0, overflow}, 64'd0);

        // abort at cycle 4 of a 10-term run; a start at cycle 2 is ignored
        x_base = 8'h60; y_base = 8'h60; len = 9'd10; clear_acc = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 2) begin
                start = 1'b1; x_base = 8'hA0; y_base = 8'hA0; len = 9'd1;
            end
            if (c == 3) begin
                start = 1'b0;
                chk("ab_xaddr3", {56'd0, x_addr}, 64'h63);
            end
            if (c == 4) abort = 1'b1;
        end
        tick();
        abort = 1'b0;
        chk("ab_busy", {63'd0, busy}, 64'd0);
        chk("ab_rd",   {62'd0, x_rd, y_rd}, 64'd0);
        done_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            if (done) done_cnt++;
            tick();
        end
        chk("ab_nodone", 64'(done_cnt), 64'd0);
        chk("ab_result", {27'd0, result}, 64'h3_FFF8_0003);

        // reset at cycle 3 of a run, then a clean run
        x_base = 8'h10; y_base = 8'h20; len = 9'd3; clear_acc = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        check_reset_state("mrst");
        reset_n = 1'b1;
        tick();
        do_run(8'h10, 8'h20, 9'd3, 1'b1, 1'b0, 1'b0);
        chk("r_cycles", 64'(cyc), 64'd5);
        chk("r_result", {27'd0, result}, 64'd32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
